// File: rtl/mprj_ram_arbiter_if.sv
// mprj_ram_arbiter_if: bundles the Wishbone slave, accelerator requester, RAM and status signals of mprj_ram_arbiter
// slave  modport: arbiter side, takes wbs_*_i / acc_req,acc_we,acc_addr,acc_wdata / ram_rdata,
//                 drives wbs_ack_o,wbs_dat_o / acc_ack,acc_rdata / ram_en,ram_we,ram_addr,ram_wdata / arb_busy,grant_acc
// master modport: environment side (Wishbone master, accelerator, RAM model), the mirror image
interface mprj_ram_arbiter_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        acc_req;
    logic        acc_we;
    logic [9:0]  acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_ack;
    logic [31:0] acc_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        arb_busy;
    logic        grant_acc;
    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
               acc_req, acc_we, acc_addr, acc_wdata, ram_rdata,
        output wbs_ack_o, wbs_dat_o, acc_ack, acc_rdata,
               ram_en, ram_we, ram_addr, ram_wdata, arb_busy, grant_acc
    );
    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
               acc_req, acc_we, acc_addr, acc_wdata, ram_rdata,
        input  wbs_ack_o, wbs_dat_o, acc_ack, acc_rdata,
               ram_en, ram_we, ram_addr, ram_wdata, arb_busy, grant_acc
    );
endinterface

// File: rtl/mprj_ram_arbiter.sv
// mprj_ram_arbiter: shares one single-port user RAM between a Wishbone slave port and an accelerator requester
// Ports: wb_clk_i clock, wb_rst_i synchronous active-high reset, bus (mprj_ram_arbiter_if.slave) carrying
//        the Wishbone slave, accelerator, RAM and status (arb_busy, grant_acc) signals.
// Parameters: DELAYS (1..15) wait cycles charged after the RAM read data is captured, BASE = wbs_adr_i[31:24] of the RAM.
// Option: define MPRJ_ARB_RR_EN for round-robin on simultaneous requests; default is fixed Wishbone priority.
module mprj_ram_arbiter #(
    parameter int unsigned DELAYS = 10,
    parameter logic [7:0]  BASE   = 8'h38
) (
    input logic               wb_clk_i,
    input logic               wb_rst_i,
    mprj_ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;
    localparam logic [3:0] LAST = 4'(DELAYS - 1);
    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        first;
    logic        gnt_q;
    logic        ack_q;
    logic        rd_q;
    logic [9:0]  addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  we_q;
    logic [31:0] rdata_q;
    logic        wb_req;
    logic        pick_acc;
    logic        grant;
    logic [9:0]  win_addr;
    logic [31:0] win_wdata;
    logic [3:0]  win_we;
    assign wb_req = bus.wbs_cyc_i & bus.wbs_stb_i & (bus.wbs_adr_i[31:24] == BASE);
    assign grant  = (state == IDLE) & (wb_req | bus.acc_req);
`ifdef MPRJ_ARB_RR_EN
    logic last_acc;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) last_acc <= 1'b1;
        else if (grant) last_acc <= pick_acc;
    end
    // on a tie the requester that did not win last time gets the RAM
    assign pick_acc = bus.acc_req & (~wb_req | ~last_acc);
`else
    assign pick_acc = bus.acc_req & ~wb_req;
`endif
    assign win_addr  = pick_acc ? bus.acc_addr : bus.wbs_adr_i[11:2];
    assign win_wdata = pick_acc ? bus.acc_wdata : bus.wbs_dat_i;
    assign win_we    = pick_acc ? (bus.acc_we ? 4'hF : 4'h0) : (bus.wbs_we_i ? bus.wbs_sel_i : 4'h0);
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE:   state_nxt = grant ? ACCESS : IDLE;
            ACCESS: begin
                state_nxt = WAIT;
                cnt_nxt   = '0;
            end
            // the first WAIT cycle is spent capturing RAM data; the DELAYS count starts after it
            WAIT:   if (!first) begin
                state_nxt = (cnt == LAST) ? ACK : WAIT;
                cnt_nxt   = (cnt == LAST) ? cnt : cnt + 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            first   <= 1'b0;
            gnt_q   <= 1'b0;
            ack_q   <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            first <= state == ACCESS;
            ack_q <= state_nxt == ACK;
            if (grant) begin
                gnt_q   <= pick_acc;
                rd_q    <= pick_acc ? ~bus.acc_we : ~bus.wbs_we_i;
                addr_q  <= win_addr;
                wdata_q <= win_wdata;
                we_q    <= win_we;
                rdata_q <= '0;
            end
            // writes keep the register at zero so the ack cycle drives 0
            if (state == WAIT && first && rd_q) rdata_q <= bus.ram_rdata;
        end
    end
    assign bus.ram_en    = state == ACCESS;
    assign bus.ram_we    = bus.ram_en ? we_q : 4'h0;
    assign bus.ram_addr  = bus.ram_en ? addr_q : 10'h0;
    assign bus.ram_wdata = bus.ram_en ? wdata_q : 32'h0;
    // an aborted Wishbone cycle still finishes on the RAM but is never acked
    assign bus.wbs_ack_o = ack_q & ~gnt_q & bus.wbs_cyc_i;
    assign bus.acc_ack   = ack_q & gnt_q;
    assign bus.wbs_dat_o = bus.wbs_ack_o ? rdata_q : 32'h0;
    assign bus.acc_rdata = bus.acc_ack ? rdata_q : 32'h0;
    assign bus.arb_busy  = state != IDLE;
    assign bus.grant_acc = gnt_q;
endmodule

// File: tb/tb_mprj_ram_arbiter.sv
// tb_mprj_ram_arbiter: directed and random transactions against a reference memory and timing rules
module tb_mprj_ram_arbiter;
    localparam int D = 10;
    localparam logic [7:0] B = 8'h38;
    localparam int TMO = 4 * D + 40;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];
    mprj_ram_arbiter_if bus();
    mprj_ram_arbiter #(.DELAYS(D), .BASE(B)) dut (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (bus.ram_en) begin
            bus.ram_rdata <= mem[bus.ram_addr];
            for (int b = 0; b < 4; b++)
                if (bus.ram_we[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
        end
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic idle_inputs();
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0; bus.wbs_sel_i = 0;
        bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
        bus.acc_req = 0; bus.acc_we = 0; bus.acc_addr = 0; bus.acc_wdata = 0;
    endtask
    task automatic ref_write(input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
        for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    endtask
    task automatic chk_all_zero(input string tag);
        chk({tag, "_ram"}, {bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata}, 64'h0);
        chk({tag, "_wb"}, {bus.wbs_ack_o, bus.wbs_dat_o}, 64'h0);
        chk({tag, "_acc"}, {bus.acc_ack, bus.acc_rdata}, 64'h0);
        chk({tag, "_status"}, {bus.arb_busy, bus.grant_acc}, 64'h0);
    endtask
    // one complete transaction from an idle arbiter; caller is at a negedge
    task automatic do_tx(input bit acc, input logic [31:0] adr, input bit we, input logic [3:0] sel,
                         input logic [31:0] data, output logic [31:0] got);
        int n, ens, oth, datbad;
        bit seen;
        logic [9:0] a, s_addr;
        logic [3:0] s_we, exp_we;
        logic [31:0] s_wdata, expd;
        logic s_gnt;
        a = acc ? adr[9:0] : adr[11:2];
        exp_we = we ? (acc ? 4'hF : sel) : 4'h0;
        expd = we ? 32'h0 : ref_mem[a];
        n = 0; ens = 0; oth = 0; datbad = 0; seen = 0; got = '0;
        s_addr = '0; s_we = '0; s_wdata = '0; s_gnt = 1'b0;
        if (acc) begin
            bus.acc_req = 1; bus.acc_we = we; bus.acc_addr = adr[9:0]; bus.acc_wdata = data;
        end else begin
            bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = we; bus.wbs_sel_i = sel;
            bus.wbs_adr_i = adr; bus.wbs_dat_i = data;
        end
        while (!seen && n < TMO) begin
            n++;
            @(negedge clk);
            if (bus.ram_en) begin
                ens++; s_addr = bus.ram_addr; s_we = bus.ram_we; s_wdata = bus.ram_wdata; s_gnt = bus.grant_acc;
            end
            if (acc ? bus.wbs_ack_o : bus.acc_ack) oth++;
            if (acc ? bus.acc_ack : bus.wbs_ack_o) begin
                seen = 1;
                got = acc ? bus.acc_rdata : bus.wbs_dat_o;
            end else if (bus.wbs_dat_o !== 32'h0 || bus.acc_rdata !== 32'h0) datbad++;
        end
        chk("tx_ack_seen", 64'(seen), 64'h1);
        chk("tx_latency", 64'(n), 64'(D + 3));
        chk("tx_en_count", 64'(ens), 64'h1);
        chk("tx_ram_addr", 64'(s_addr), 64'(a));
        chk("tx_ram_we", 64'(s_we), 64'(exp_we));
        chk("tx_grant", 64'(s_gnt), 64'(acc));
        if (we) chk("tx_ram_wdata", 64'(s_wdata), 64'(data));
        chk("tx_rdata", 64'(got), 64'(expd));
        chk("tx_other_ack", 64'(oth), 64'h0);
        chk("tx_dat_outside_ack", 64'(datbad), 64'h0);
        idle_inputs();
        @(negedge clk);
        chk("tx_ack_one_cycle", {bus.wbs_ack_o, bus.acc_ack}, 64'h0);
        chk("tx_dat_after", {bus.wbs_dat_o, bus.acc_rdata}, 64'h0);
        chk("tx_idle_after", 64'(bus.arb_busy), 64'h0);
        if (we) ref_write(a, exp_we, data);
    endtask
    initial begin
        logic [31:0] got, v;
        int wb_n, acc_n, bad, busybad, ens, acks, n;
        bit prev, seen, acc;
        logic [9:0] idx;
        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            mem[i] = v;
            ref_mem[i] = v;
        end
        idle_inputs();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 0;
        @(negedge clk);
        chk("post_reset_en", 64'(bus.ram_en), 64'h0);
        // basic word write then read-back
        do_tx(0, 32'h3800_0010, 1, 4'hF, 32'h1122_3344, got);
        do_tx(0, 32'h3800_0010, 0, 4'hF, 32'h0, got);
        chk("readback_word", 64'(got), 64'h1122_3344);
        // byte lane write
        do_tx(0, 32'h3800_0010, 1, 4'b0010, 32'h0000_AB00, got);
        do_tx(0, 32'h3800_0010, 0, 4'hF, 32'h0, got);
        chk("readback_byte", 64'(got), 64'h1122_AB44);
        // address outside the RAM window is ignored
        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_adr_i = 32'h3000_0000; bus.wbs_we_i = 1; bus.wbs_sel_i = 4'hF;
        ens = 0; acks = 0; bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ens += int'(bus.ram_en);
            acks += int'(bus.wbs_ack_o);
            bad += int'(bus.arb_busy);
        end
        chk("foreign_en", 64'(ens), 64'h0);
        chk("foreign_ack", 64'(acks), 64'h0);
        chk("foreign_busy", 64'(bad), 64'h0);
        idle_inputs();
        @(negedge clk);
        // both requesters held: Wishbone wins every arbitration, accelerator waits
        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0; bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = 32'h3800_0020;
        bus.acc_req = 1; bus.acc_we = 0; bus.acc_addr = 10'd5;
        wb_n = 0; acc_n = 0; bad = 0; busybad = 0; prev = 0;
        for (int i = 1; i <= 5 * (D + 4); i++) begin
            @(negedge clk);
            if (prev && bus.arb_busy) busybad++;
            prev = bus.wbs_ack_o;
            if (bus.wbs_ack_o) begin
                wb_n++;
                if (bus.wbs_dat_o !== ref_mem[8]) bad++;
            end
            acc_n += int'(bus.acc_ack);
        end
        chk("held_wb_acks", 64'(wb_n), 64'd5);
        chk("held_acc_starved", 64'(acc_n), 64'h0);
        chk("held_wb_data", 64'(bad), 64'h0);
        chk("held_idle_after_ack", 64'(busybad), 64'h0);
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
        n = 0; seen = 0; got = '0;
        while (!seen && n < TMO) begin
            n++;
            @(negedge clk);
            if (bus.acc_ack) begin seen = 1; got = bus.acc_rdata; end
        end
        chk("released_acc_latency", 64'(n), 64'(D + 3));
        chk("released_acc_data", 64'(got), 64'(ref_mem[5]));
        chk("released_acc_grant", 64'(bus.grant_acc), 64'h1);
        idle_inputs();
        @(negedge clk);
        // Wishbone abort: RAM write completes, no ack
        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 1; bus.wbs_sel_i = 4'hF;
        bus.wbs_adr_i = 32'h3800_0040; bus.wbs_dat_i = 32'hCAFE_F00D;
        ens = 0; acks = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ens += int'(bus.ram_en);
        end
        idle_inputs();
        for (int i = 0; i < D + 6; i++) begin
            @(negedge clk);
            ens += int'(bus.ram_en);
            acks += int'(bus.wbs_ack_o);
        end
        chk("abort_en", 64'(ens), 64'h1);
        chk("abort_ack", 64'(acks), 64'h0);
        chk("abort_idle", 64'(bus.arb_busy), 64'h0);
        ref_write(10'd16, 4'hF, 32'hCAFE_F00D);
        do_tx(0, 32'h3800_0040, 0, 4'hF, 32'h0, got);
        chk("abort_readback", 64'(got), 64'hCAFE_F00D);
        // reset in the middle of an accelerator read
        bus.acc_req = 1; bus.acc_we = 0; bus.acc_addr = 10'd7;
        repeat (5) @(negedge clk);
        chk("mid_wait_busy", 64'(bus.arb_busy), 64'h1);
        rst = 1;
        bus.acc_req = 0;
        @(negedge clk);
        chk_all_zero("mid_reset");
        rst = 0;
        acks = 0; ens = 0;
        for (int i = 0; i < D + 6; i++) begin
            @(negedge clk);
            acks += int'(bus.acc_ack);
            ens += int'(bus.ram_en);
        end
        chk("dropped_ack", 64'(acks), 64'h0);
        chk("dropped_en", 64'(ens), 64'h0);
        do_tx(1, 32'd7, 0, 4'h0, 32'h0, got);
        // random mix from both requesters
        for (int k = 0; k < 40; k++) begin
            acc = 1'($urandom_range(0, 1));
            idx = 10'($urandom_range(0, 15));
            v = acc ? {22'($urandom), idx} : {B, 12'($urandom), idx, 2'($urandom)};
            do_tx(acc, v, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, got);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
